// File: rtl/issue_pkg.sv
// Shared types for the issue queue: per-slot entry record and tag-match helper.
// Default tag/payload widths live here; the top-level parameters default to them.
package issue_pkg;

   localparam int unsigned TAG_W_DEF     = 6;
   localparam int unsigned PAYLOAD_W_DEF = 64;

   typedef struct packed {
      logic                     valid;
      logic [TAG_W_DEF-1:0]     src1_tag;
      logic                     src1_rdy;
      logic [TAG_W_DEF-1:0]     src2_tag;
      logic                     src2_rdy;
      logic [PAYLOAD_W_DEF-1:0] payload;
   } iq_entry_t;

   function automatic logic tag_hit(input logic                 bcast_valid,
                                    input logic [TAG_W_DEF-1:0] bcast_tag,
                                    input logic [TAG_W_DEF-1:0] src_tag);
      return bcast_valid && (bcast_tag == src_tag);
   endfunction

endpackage

// File: rtl/iq_entry.sv
// One issue-queue slot: operand storage, CDB wakeup compare and issue request bit.
// ISSUE_WAKEUP_BYPASS_EN lets a slot request in the same cycle its last operand is broadcast.
module iq_entry
   import issue_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr,
   input  iq_entry_t                wr_entry,
   input  logic                     clr,
   input  logic                     cdb_valid,
   input  logic [TAG_W_DEF-1:0]     cdb_tag,
   output logic                     valid,
   output logic                     req,
   output logic [PAYLOAD_W_DEF-1:0] payload
);

   iq_entry_t entry_q, entry_d;
   logic      hit1, hit2;

   assign hit1 = tag_hit(cdb_valid, cdb_tag, entry_q.src1_tag);
   assign hit2 = tag_hit(cdb_valid, cdb_tag, entry_q.src2_tag);

   always_comb begin
      entry_d = entry_q;
      if (flush) begin
         entry_d.valid = 1'b0;
      end else if (wr) begin
         // A broadcast coinciding with allocation must not be lost.
         entry_d          = wr_entry;
         entry_d.valid    = 1'b1;
         entry_d.src1_rdy = wr_entry.src1_rdy | tag_hit(cdb_valid, cdb_tag, wr_entry.src1_tag);
         entry_d.src2_rdy = wr_entry.src2_rdy | tag_hit(cdb_valid, cdb_tag, wr_entry.src2_tag);
      end else if (clr) begin
         entry_d.valid = 1'b0;
      end else if (entry_q.valid) begin
         entry_d.src1_rdy = entry_q.src1_rdy | hit1;
         entry_d.src2_rdy = entry_q.src2_rdy | hit2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entry_q <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign valid   = entry_q.valid;
   assign payload = entry_q.payload;

`ifdef ISSUE_WAKEUP_BYPASS_EN
   assign req = entry_q.valid & (entry_q.src1_rdy | hit1) & (entry_q.src2_rdy | hit2);
`else
   assign req = entry_q.valid & entry_q.src1_rdy & entry_q.src2_rdy;
`endif

endmodule

// File: rtl/issue_queue.sv
// Out-of-order issue queue: DEPTH slots, lowest-free allocation, external select grant.
// Optional ISSUE_WAKEUP_BYPASS_EN adds same-cycle CDB wakeup into req_vec.
module issue_queue
   import issue_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned IDX_W     = $clog2(DEPTH),
   parameter int unsigned TAG_W     = TAG_W_DEF,
   parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 alloc_valid,
   output logic                 alloc_ready,
   input  logic [TAG_W-1:0]     alloc_src1_tag,
   input  logic                 alloc_src1_rdy,
   input  logic [TAG_W-1:0]     alloc_src2_tag,
   input  logic                 alloc_src2_rdy,
   input  logic [PAYLOAD_W-1:0] alloc_payload,
   input  logic                 cdb_valid,
   input  logic [TAG_W-1:0]     cdb_tag,
   output logic [DEPTH-1:0]     req_vec,
   input  logic                 grant_valid,
   input  logic [IDX_W-1:0]     grant_idx,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [PAYLOAD_W-1:0] issue_payload,
   output logic [IDX_W:0]       count
);

   localparam int unsigned CNT_W = IDX_W + 1;

   logic [DEPTH-1:0]     slot_valid;
   logic [PAYLOAD_W-1:0] slot_payload [DEPTH];
   logic [DEPTH-1:0]     free_sel;
   logic                 alloc_fire, issue_fire;
   logic [CNT_W-1:0]     count_q, count_d;
   iq_entry_t            wr_entry;

   // Ready depends only on registered occupancy, so a slot freed this cycle is not reused yet.
   assign alloc_ready = !flush && (count_q != CNT_W'(DEPTH));
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign issue_valid = !flush && grant_valid && req_vec[grant_idx];
   assign issue_fire  = issue_valid && issue_ready;
   assign issue_payload = slot_valid[grant_idx] ? slot_payload[grant_idx] : '0;
   assign count       = count_q;

   assign wr_entry = '{valid:    1'b1,
                       src1_tag: alloc_src1_tag,
                       src1_rdy: alloc_src1_rdy,
                       src2_tag: alloc_src2_tag,
                       src2_rdy: alloc_src2_rdy,
                       payload:  alloc_payload};

   always_comb begin
      logic found;
      free_sel = '0;
      found    = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (!slot_valid[i] && !found) begin
            free_sel[i] = 1'b1;
            found       = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < int'(DEPTH); g++) begin : g_slot
      iq_entry u_entry (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .wr        (alloc_fire && free_sel[g]),
         .wr_entry  (wr_entry),
         .clr       (issue_fire && (grant_idx == IDX_W'(g))),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .valid     (slot_valid[g]),
         .req       (req_vec[g]),
         .payload   (slot_payload[g])
      );
   end

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (alloc_fire && !issue_fire) begin
         count_d = count_q + CNT_W'(1);
      end else if (!alloc_fire && issue_fire) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
